bullet_pool_manager: RTL

//  Owns up to NUM_BULLETS player bullets: spawns them on fire requests, moves them up once per frame,
//  and retires them at the screen top or on collision. Per pixel it produces anyBulletDrawingRequest
//  and bulletRGB, which feed the objects mux directly (bullet layer sits below enemies and above background).

---
 rtl/bullet_pkg.sv | 18 +
 rtl/bullet_pool_manager_if.sv | 18 +
 rtl/bullet_box_hit.sv | 35 +++
 rtl/bullet_pool_manager.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared definitions for the player-bullet pool: coordinate width, screen
// geometry, RGB332 colour constants and the per-slot state record.
package bullet_pkg;

  localparam int COORD_W  = 11;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [7:0] RGB_BLACK  = 8'h00;
  localparam logic [7:0] RGB_YELLOW = 8'hFC;

  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } bullet_t;

endpackage

// File: rtl/bullet_pool_manager_if.sv
// Fire-request handshake between the player logic (master) and the bullet
// pool (slave).
//   fireReq  master->slave  level request, held until fireAck
//   fireX    master->slave  spawn column (bullet left edge)
//   fireY    master->slave  spawn row (bullet top edge)
//   fireAck  slave->master  one-cycle pulse: request accepted
interface bullet_pool_manager_if;
  import bullet_pkg::*;

  logic               fireReq;
  logic [COORD_W-1:0] fireX;
  logic [COORD_W-1:0] fireY;
  logic               fireAck;

  modport master (output fireReq, output fireX, output fireY, input fireAck);
  modport slave  (input fireReq, input fireX, input fireY, output fireAck);

endinterface

// File: rtl/bullet_box_hit.sv
// Combinational box test: does the current pixel fall inside one bullet slot.
//   slot     in   slot state {valid, x, y}
//   pixel_x  in   current pixel column
//   pixel_y  in   current pixel row
//   hit      out  slot is valid and covers the pixel
// Bounds are formed one bit wider than the coordinates so a bullet near
// 2047 does not wrap its right/bottom edge back to zero.
module bullet_box_hit
  import bullet_pkg::*;
#(
  parameter int BULLET_W = 4,
  parameter int BULLET_H = 8
) (
  input  bullet_t            slot,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               hit
);

  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(BULLET_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(BULLET_H);

  logic [COORD_W:0] x_lo, x_hi, y_lo, y_hi, px, py;

  always_comb begin
    x_lo = {1'b0, slot.x};
    y_lo = {1'b0, slot.y};
    x_hi = x_lo + W_EXT;
    y_hi = y_lo + H_EXT;
    px   = {1'b0, pixel_x};
    py   = {1'b0, pixel_y};
    hit  = slot.valid && (px >= x_lo) && (px < x_hi) && (py >= y_lo) && (py < y_hi);
  end

endmodule

// File: rtl/bullet_pool_manager.sv
// Player bullet pool: spawns bullets on fire requests, moves them up once per
// frame, retires them at the screen top or on collision, and produces the
// per-pixel bullet layer for the objects mux.
//   clk                      in   system clock
//   reset                    in   synchronous active-high reset
//   startOfFrame             in   one-cycle pulse per frame
//   pixelX, pixelY           in   current pixel
//   fire                     slave side of the fire handshake
//   collisionHit             in   bullet/enemy overlap, aligned with the draw request
//   anyBulletDrawingRequest  out  some live bullet covers the pixel (1-cycle latency)
//   bulletRGB                out  BULLET_COLOR while the request is high, else 0
//   activeCount              out  number of live slots (registered)
module bullet_pool_manager
  import bullet_pkg::*;
#(
  parameter int         NUM_BULLETS     = 8,
  parameter int         BULLET_W        = 4,
  parameter int         BULLET_H        = 8,
  parameter int         SPEED           = 4,
  parameter int         COOLDOWN_FRAMES = 8,
  parameter logic [7:0] BULLET_COLOR    = RGB_YELLOW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [COORD_W-1:0] pixelX,
  input  logic [COORD_W-1:0] pixelY,
  bullet_pool_manager_if.slave fire,
  input  logic               collisionHit,
  output logic               anyBulletDrawingRequest,
  output logic [7:0]         bulletRGB,
  output logic [4:0]         activeCount
);

  localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);

  function automatic logic [CD_W-1:0] sat_dec(input logic [CD_W-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [4:0] count_valid(input logic [NUM_BULLETS-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < NUM_BULLETS; i++) n = n + {4'b0, v[i]};
    return n;
  endfunction

  bullet_t                slot_q [NUM_BULLETS];
  bullet_t                slot_d [NUM_BULLETS];
  logic [NUM_BULLETS-1:0] valid_vec;
  logic [NUM_BULLETS-1:0] hit_vec;
  logic [CD_W-1:0]        cooldown_q;
  logic                   free_found;
  logic [IDX_W-1:0]       free_idx;
  logic [IDX_W-1:0]       hit_idx;
  logic                   fire_accept;
  logic                   collide;
  logic                   any_hit_p1;
  logic [IDX_W-1:0]       hit_idx_p1;
  logic [7:0]             rgb_p1;
  logic                   fire_ack_q;
  logic [4:0]             active_q;

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_hit
    bullet_box_hit #(
      .BULLET_W (BULLET_W),
      .BULLET_H (BULLET_H)
    ) u_hit (
      .slot    (slot_q[g]),
      .pixel_x (pixelX),
      .pixel_y (pixelY),
      .hit     (hit_vec[g])
    );
  end

  // Lowest-index free slot and lowest-index hitting slot.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    hit_idx    = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      valid_vec[i] = slot_q[i].valid;
      if (!slot_q[i].valid) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (hit_vec[i]) hit_idx = IDX_W'(i);
    end
  end

  assign fire_accept = fire.fireReq && !startOfFrame && (cooldown_q == '0) && free_found;
  assign collide     = collisionHit && any_hit_p1;

  // Allocation only ever targets a slot that was invalid at cycle start, so
  // it never collides with a move/free on the same slot; a slot freed this
  // cycle becomes allocatable next cycle.
  always_comb begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slot_d[i] = slot_q[i];
      if (startOfFrame && slot_q[i].valid) begin
        if (slot_q[i].y >= SPEED_C) slot_d[i].y = slot_q[i].y - SPEED_C;
        else                        slot_d[i].valid = 1'b0;
      end
      if (collide && (hit_idx_p1 == IDX_W'(i))) slot_d[i].valid = 1'b0;
      if (fire_accept && (free_idx == IDX_W'(i))) slot_d[i] = {1'b1, fire.fireX, fire.fireY};
    end
  end

  // ---- stage p1: slot update, draw request, hit index, counters ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BULLETS; i++) begin
      slot_q[i].x <= slot_d[i].x;
      slot_q[i].y <= slot_d[i].y;
    end
    hit_idx_p1 <= hit_idx;
    if (reset) begin
      for (int i = 0; i < NUM_BULLETS; i++) slot_q[i].valid <= 1'b0;
      cooldown_q <= '0;
      fire_ack_q <= 1'b0;
      any_hit_p1 <= 1'b0;
      rgb_p1     <= RGB_BLACK;
      active_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_BULLETS; i++) slot_q[i].valid <= slot_d[i].valid;
      if (fire_accept)       cooldown_q <= CD_LOAD;
      else if (startOfFrame) cooldown_q <= sat_dec(cooldown_q);
      fire_ack_q <= fire_accept;
      any_hit_p1 <= |hit_vec;
      rgb_p1     <= (|hit_vec) ? BULLET_COLOR : RGB_BLACK;
      active_q   <= count_valid(valid_vec);
    end
  end

  assign fire.fireAck            = fire_ack_q;
  assign anyBulletDrawingRequest = any_hit_p1;
  assign bulletRGB               = rgb_p1;
  assign activeCount             = active_q;

endmodule
